philv_execute_stage: RTL and testbench

Execute stage of the Philosophy-V multi-cycle core. It decodes the R-type funct3/funct7 fields into an ALU operation and captures the two register-file read ports in an operand register pair. It selects the B operand, computes the result combinationally and registers it as the stage output. It sits between the register file and the write-back path (`alu_out` feeds register-file write data).

---
 rtl/philv_alu_pkg.sv | 26 ++
 rtl/philv_alu.sv | 36 +++
 rtl/philv_execute_stage.sv | 84 ++++++++
 tb/tb_philv_execute_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/philv_alu_pkg.sv
// Shared ALU definitions for the Philosophy-V execute stage:
// operation codes and B-operand select encodings.
package philv_alu_pkg;

  localparam int ALU_FUNCT_WIDTH = 4;
  localparam int ALU_SRC_B_WIDTH = 2;

  // Operation codes: {funct7[5], funct3} for ADD/SUB and SRL/SRA, {0, funct3} otherwise.
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SUB  = 4'b1000;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SLL  = 4'b0001;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SLT  = 4'b0010;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SLTU = 4'b0011;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SRL  = 4'b0101;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SRA  = 4'b1101;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_OR   = 4'b0110;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_AND  = 4'b0111;

  // B-operand select encodings.
  localparam logic [ALU_SRC_B_WIDTH-1:0] SRC_B_REG  = 2'b00;
  localparam logic [ALU_SRC_B_WIDTH-1:0] SRC_B_FOUR = 2'b01;
  localparam logic [ALU_SRC_B_WIDTH-1:0] SRC_B_IMM  = 2'b10;
  localparam logic [ALU_SRC_B_WIDTH-1:0] SRC_B_ZERO = 2'b11;

endpackage

// File: rtl/philv_alu.sv
// Purely combinational ALU. Unlisted operation codes produce zero.
module philv_alu
  import philv_alu_pkg::*;
#(
  parameter int BUS_WIDTH = 32
) (
  input  logic [ALU_FUNCT_WIDTH-1:0] funct,
  input  logic [BUS_WIDTH-1:0]       x,
  input  logic [BUS_WIDTH-1:0]       y,
  output logic [BUS_WIDTH-1:0]       z
);

  localparam int SHW = $clog2(BUS_WIDTH);

  logic [SHW-1:0] shamt;
  assign shamt = y[SHW-1:0];

  // Select the result for the decoded operation.
  always_comb begin
    z = '0;
    case (funct)
      ALU_ADD:  z = x + y;
      ALU_SUB:  z = x - y;
      ALU_SLL:  z = x << shamt;
      ALU_SLT:  z[0] = $signed(x) < $signed(y);
      ALU_SLTU: z[0] = x < y;
      ALU_XOR:  z = x ^ y;
      ALU_SRL:  z = x >> shamt;
      ALU_SRA:  z = $unsigned($signed(x) >>> shamt);
      ALU_OR:   z = x | y;
      ALU_AND:  z = x & y;
      default:  z = '0;
    endcase
  end

endmodule

// File: rtl/philv_execute_stage.sv
// Execute stage: R-type decode, operand register pair, B-operand mux,
// combinational ALU and registered result feeding write-back.
module philv_execute_stage
  import philv_alu_pkg::*;
#(
  parameter int BUS_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic [BUS_WIDTH-1:0]       rd_a,
  input  logic [BUS_WIDTH-1:0]       rd_b,
  input  logic [BUS_WIDTH-1:0]       imm,
  input  logic [2:0]                 funct3,
  input  logic [6:0]                 funct7,
  input  logic [ALU_SRC_B_WIDTH-1:0] src_b_sel,
  output logic [ALU_FUNCT_WIDTH-1:0] alu_funct,
  output logic [BUS_WIDTH-1:0]       alu_result,
  output logic [BUS_WIDTH-1:0]       alu_out
);

  logic [BUS_WIDTH-1:0] qa_q, qb_q, qa_d, qb_d;
  logic [BUS_WIDTH-1:0] alu_out_q;
  logic [BUS_WIDTH-1:0] src_b;
  logic                 funct7_unused;

  // Only funct7[5] distinguishes SUB/SRA; the remaining bits carry no meaning here.
  assign funct7_unused = ^{funct7[6], funct7[4:0]};

  // Decode funct3/funct7 into the ALU operation code.
  always_comb begin
    alu_funct = {1'b0, funct3};
    if (funct3 == 3'b000 || funct3 == 3'b101) alu_funct = {funct7[5], funct3};
  end

  // Operand next-state: load on enable, otherwise hold.
  always_comb begin
    qa_d = qa_q;
    qb_d = qb_q;
    if (ena) begin
      qa_d = rd_a;
      qb_d = rd_b;
    end
  end

  // Operand register pair; reset wins over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      qa_q <= '0;
      qb_q <= '0;
    end else begin
      qa_q <= qa_d;
      qb_q <= qb_d;
    end
  end

  // B-operand select.
  always_comb begin
    src_b = '0;
    case (src_b_sel)
      SRC_B_REG:  src_b = qb_q;
      SRC_B_FOUR: src_b = BUS_WIDTH'(4);
      SRC_B_IMM:  src_b = imm;
      SRC_B_ZERO: src_b = '0;
      default:    src_b = '0;
    endcase
  end

  philv_alu #(.BUS_WIDTH(BUS_WIDTH)) u_alu (
    .funct (alu_funct),
    .x     (qa_q),
    .y     (src_b),
    .z     (alu_result)
  );

  // Result register loads every cycle, independent of ena.
  always_ff @(posedge clk) begin
    if (rst) alu_out_q <= '0;
    else     alu_out_q <= alu_result;
  end

  assign alu_out = alu_out_q;

endmodule

// File: tb/tb_philv_execute_stage.sv
// Self-checking bench for philv_execute_stage (BUS_WIDTH = 32).
module tb_philv_execute_stage;

  logic        clk;
  logic        rst;
  logic        ena;
  logic [31:0] rd_a, rd_b, imm;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [1:0]  src_b_sel;
  logic [3:0]  alu_funct;
  logic [31:0] alu_result, alu_out;

  int n_checks = 0;
  int n_fail   = 0;

  philv_execute_stage #(.BUS_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .rd_a       (rd_a),
    .rd_b       (rd_b),
    .imm        (imm),
    .funct3     (funct3),
    .funct7     (funct7),
    .src_b_sel  (src_b_sel),
    .alu_funct  (alu_funct),
    .alu_result (alu_result),
    .alu_out    (alu_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: expected operation code from the instruction fields.
  function automatic logic [3:0] ref_funct(input logic [2:0] f3, input logic [6:0] f7);
    if (f3 == 3'd0 || f3 == 3'd5) return {f7[5], f3};
    return {1'b0, f3};
  endfunction

  // Reference: behaviour of an R-type instruction on operands a and b.
  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [6:0] f7,
                                         input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    longint sa, sb;
    sh = b % 32;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f3)
      3'd0: return f7[5] ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return (sa < sb) ? 32'd1 : 32'd0;
      3'd3: return ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return f7[5] ? 32'(sa >>> sh) : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic [31:0] ref_b(input logic [1:0] sel, input logic [31:0] qb, input logic [31:0] im);
    case (sel)
      2'd0: return qb;
      2'd1: return 32'd4;
      2'd2: return im;
      default: return 32'd0;
    endcase
  endfunction

  typedef struct {
    string       name;
    logic [31:0] a, b, im;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [1:0]  sel;
    logic [3:0]  exp_funct;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctl(input logic [2:0] f3, input logic [6:0] f7, input logic [1:0] sel, input logic [31:0] im);
    funct3 = f3; funct7 = f7; src_b_sel = sel; imm = im;
  endtask

  logic [31:0] mqa, mqb, mout, exp_r;

  initial begin
    vecs[0]  = '{"add_wrap",  32'hFFFFFFFF, 32'h1,        32'h0,  3'd0, 7'h00, 2'd0, 4'b0000, 32'h00000000};
    vecs[1]  = '{"sub",       32'hFFFFFFFF, 32'h1,        32'h0,  3'd0, 7'h20, 2'd0, 4'b1000, 32'hFFFFFFFE};
    vecs[2]  = '{"sll",       32'h80000000, 32'h24,       32'h0,  3'd1, 7'h00, 2'd0, 4'b0001, 32'h00000000};
    vecs[3]  = '{"srl",       32'h80000000, 32'h24,       32'h0,  3'd5, 7'h00, 2'd0, 4'b0101, 32'h08000000};
    vecs[4]  = '{"sra",       32'h80000000, 32'h24,       32'h0,  3'd5, 7'h20, 2'd0, 4'b1101, 32'hF8000000};
    vecs[5]  = '{"slt",       32'hFFFFFFFF, 32'h1,        32'h0,  3'd2, 7'h00, 2'd0, 4'b0010, 32'h00000001};
    vecs[6]  = '{"sltu",      32'hFFFFFFFF, 32'h1,        32'h0,  3'd3, 7'h00, 2'd0, 4'b0011, 32'h00000000};
    vecs[7]  = '{"xor_f7ign", 32'h0000F0F0, 32'h00000FF0, 32'h0,  3'd4, 7'h20, 2'd0, 4'b0100, 32'h0000FF00};
    vecs[8]  = '{"add_four",  32'h00001000, 32'h12345678, 32'h0,  3'd0, 7'h00, 2'd1, 4'b0000, 32'h00001004};
    vecs[9]  = '{"b_zero",    32'h00001234, 32'h00000099, 32'h55, 3'd0, 7'h00, 2'd3, 4'b0000, 32'h00001234};
    vecs[10] = '{"or_imm",    32'h00000005, 32'h0,        32'h10, 3'd6, 7'h00, 2'd2, 4'b0110, 32'h00000015};
    vecs[11] = '{"sll_upper", 32'h00000001, 32'h00000021, 32'h0,  3'd1, 7'h20, 2'd0, 4'b0001, 32'h00000002};

    rst = 1'b1; ena = 1'b1; rd_a = 32'hDEAD0001; rd_b = 32'hBEEF0002;
    set_ctl(3'd0, 7'h00, 2'd0, 32'h1111);

    // Reset with nonzero inputs and ena=1
    tick();
    rst = 1'b0; ena = 1'b0;
    #1;
    check("reset_alu_out", alu_out, 32'd0);
    check("reset_add_zero", alu_result, 32'd0);
    src_b_sel = 2'd1;
    #1;
    check("reset_add_four", alu_result, 32'd4);

    // Table-driven single operations: capture, compute, register
    for (int i = 0; i < 12; i++) begin
      rd_a = vecs[i].a; rd_b = vecs[i].b; ena = 1'b1;
      tick();
      ena = 1'b0; rd_a = ~vecs[i].a; rd_b = ~vecs[i].b;
      set_ctl(vecs[i].f3, vecs[i].f7, vecs[i].sel, vecs[i].im);
      #1;
      check({vecs[i].name, "_funct"}, {28'd0, alu_funct}, {28'd0, vecs[i].exp_funct});
      check({vecs[i].name, "_result"}, alu_result, vecs[i].exp_res);
      tick();
      check({vecs[i].name, "_out"}, alu_out, vecs[i].exp_res);
    end

    // Hold: operands frozen, operation changes each cycle
    rd_a = 32'd6; rd_b = 32'd3; ena = 1'b1;
    tick();
    ena = 1'b0; rd_a = 32'd100; rd_b = 32'd200;
    set_ctl(3'd7, 7'h00, 2'd0, 32'h0);
    #1; check("hold_and", alu_result, 32'd2);
    tick(); check("hold_and_out", alu_out, 32'd2);
    funct3 = 3'd6;
    #1; check("hold_or", alu_result, 32'd7);
    tick(); check("hold_or_out", alu_out, 32'd7);
    funct3 = 3'd4;
    #1; check("hold_xor", alu_result, 32'd5);
    tick(); check("hold_xor_out", alu_out, 32'd5);

    // Streaming: one result per cycle
    set_ctl(3'd0, 7'h00, 2'd0, 32'h0);
    rd_a = 32'd10; rd_b = 32'd3; ena = 1'b1;
    tick();
    rd_a = 32'd20; rd_b = 32'd5;
    #1; check("stream_r0", alu_result, 32'd13);
    tick();
    rd_a = 32'd30; rd_b = 32'd7;
    #1; check("stream_o0", alu_out, 32'd13);
    check("stream_r1", alu_result, 32'd25);
    tick();
    ena = 1'b0;
    #1; check("stream_o1", alu_out, 32'd25);
    check("stream_r2", alu_result, 32'd37);
    tick();
    check("stream_o2", alu_out, 32'd37);

    // Reset mid-stream discards in-flight operands
    rd_a = 32'd100; rd_b = 32'd1; ena = 1'b1;
    tick();
    rst = 1'b1; rd_a = 32'd55; rd_b = 32'd66;
    tick();
    rst = 1'b0; ena = 1'b0;
    #1;
    check("midrst_out", alu_out, 32'd0);
    check("midrst_result", alu_result, 32'd0);

    // Randomized run against a cycle model of the stage
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mqa = 32'd0; mqb = 32'd0; mout = 32'd0;
    for (int c = 0; c < 300; c++) begin
      rst = ($urandom_range(0, 24) == 0);
      ena = $urandom_range(0, 1) == 1;
      rd_a = $urandom();
      rd_b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
      set_ctl(3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)),
              2'($urandom_range(0, 3)), $urandom());
      #1;
      exp_r = ref_op(funct3, funct7, mqa, ref_b(src_b_sel, mqb, imm));
      check("rand_funct", {28'd0, alu_funct}, {28'd0, ref_funct(funct3, funct7)});
      check("rand_result", alu_result, exp_r);
      check("rand_out", alu_out, mout);
      if (rst) begin
        mqa = 32'd0; mqb = 32'd0; mout = 32'd0;
      end else begin
        mout = exp_r;
        if (ena) begin
          mqa = rd_a; mqb = rd_b;
        end
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
